decode_order_mux: RTL

- Successor to the single-register decode stage-3 mux.
- Accepts decoded instructions from NUM_FMT format-specific decoders, each through its own valid/ready channel.
- Buffers each channel in a per-channel FIFO and re-serialises them oldest-first by (majId, minId).
- Presents one registered output with valid/ready backpressure to rename/dispatch, and supports a pipeline flush.

---
 rtl/decode_order_mux_pkg.sv | 64 ++++++
 rtl/decode_order_mux_chan_fifo.sv | 68 ++++++
 rtl/decode_order_mux.sv | 117 +++++++++++
 3 files changed

// File: rtl/decode_order_mux_pkg.sv
// Shared payload layout, decoder format codes and the age comparison used to
// re-serialise decoded instructions oldest-first.
package decode_pkg;

  localparam int OPCODE_WID  = 12;
  localparam int ADDR_WID    = 64;
  localparam int FU_WID      = 3;
  localparam int MAJID_WID   = 64;
  localparam int MINID_WID   = 7;
  localparam int IS64_WID    = 1;
  localparam int PID_WID     = 20;
  localparam int TID_WID     = 16;
  localparam int OPRW_WID    = 2;
  localparam int OPISREG_WID = 1;
  localparam int BODY_WID    = 84;

  // Field offsets from the payload LSB; fields are packed in declaration order.
  localparam int OPCODE_OFF  = 0;
  localparam int ADDR_OFF    = OPCODE_OFF + OPCODE_WID;
  localparam int FU_OFF      = ADDR_OFF + ADDR_WID;
  localparam int MAJID_OFF   = FU_OFF + FU_WID;
  localparam int MINID_OFF   = MAJID_OFF + MAJID_WID;
  localparam int IS64_OFF    = MINID_OFF + MINID_WID;
  localparam int PID_OFF     = IS64_OFF + IS64_WID;
  localparam int TID_OFF     = PID_OFF + PID_WID;
  localparam int OPRW_BASE   = TID_OFF + TID_WID;
  localparam int OPRW_OFF [4] = '{OPRW_BASE, OPRW_BASE + 2, OPRW_BASE + 4, OPRW_BASE + 6};
  localparam int OPISREG_BASE = OPRW_BASE + 4 * OPRW_WID;
  localparam int OPISREG_OFF [4] = '{OPISREG_BASE, OPISREG_BASE + 1, OPISREG_BASE + 2,
                                     OPISREG_BASE + 3};
  localparam int BODY_OFF    = OPISREG_BASE + 4 * OPISREG_WID;
  localparam int PAYLOAD_WID = BODY_OFF + BODY_WID;

  typedef struct packed {
    logic [BODY_WID-1:0]   body;
    logic [3:0]            opisreg;
    logic [7:0]            oprw;
    logic [TID_WID-1:0]    tid;
    logic [PID_WID-1:0]    pid;
    logic                  is64;
    logic [MINID_WID-1:0]  minid;
    logic [MAJID_WID-1:0]  majid;
    logic [FU_WID-1:0]     fu;
    logic [ADDR_WID-1:0]   addr;
    logic [OPCODE_WID-1:0] opcode;
  } decode_payload_t;

  localparam logic [7:0] FMT_INT = 8'b0000_0001;
  localparam logic [7:0] FMT_FP  = 8'b0000_0010;
  localparam logic [7:0] FMT_VEC = 8'b0000_0100;
  localparam logic [7:0] FMT_MEM = 8'b0000_1000;

  // Serial-number age test: a is older than b when (a-b) is negative mod 2^W.
  function automatic logic older(input logic [MAJID_WID-1:0] a_maj,
                                 input logic [MINID_WID-1:0] a_min,
                                 input logic [MAJID_WID-1:0] b_maj,
                                 input logic [MINID_WID-1:0] b_min);
    logic [MAJID_WID-1:0] diff;
    diff = a_maj - b_maj;
    if (diff != '0) return diff[MAJID_WID-1];
    return a_min < b_min;
  endfunction

endpackage

// File: rtl/decode_order_mux_chan_fifo.sv
// Per-channel synchronous FIFO with flush and a combinational head read.
module decode_chan_fifo
  import decode_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_WID,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Ready is !full from registered state only, so a same-cycle pop never frees a slot.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/decode_order_mux.sv
// Merges per-format decoder channels into one oldest-first registered stream
// toward rename/dispatch, with backpressure and pipeline flush.
module decode_order_mux
  import decode_pkg::*;
#(
  parameter int NUM_FMT    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int OPCODE_W   = 12,
  parameter int ADDR_W     = 64,
  parameter int FU_W       = 3,
  parameter int MAJID_W    = 64,
  parameter int MINID_W    = 7,
  parameter int PID_W      = 20,
  parameter int TID_W      = 16,
  parameter int BODY_W     = 84,
  localparam int PAYLOAD_W = OPCODE_W + ADDR_W + FU_W + MAJID_W + MINID_W + 1 + PID_W
                             + TID_W + 8 + 4 + BODY_W,
  localparam int CH_W      = $clog2(NUM_FMT),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [NUM_FMT-1:0]           in_valid_i,
  output logic [NUM_FMT-1:0]           in_ready_o,
  input  logic [NUM_FMT*PAYLOAD_W-1:0] in_payload_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic [CH_W-1:0]              out_channel_o,
  output logic [NUM_FMT*CNT_W-1:0]     occupancy_o
);

  localparam int MAJ_OFF = OPCODE_W + ADDR_W + FU_W;
  localparam int MIN_OFF = MAJ_OFF + MAJID_W;

  logic [PAYLOAD_W-1:0] head [NUM_FMT];
  logic [MAJID_W-1:0]   maj  [NUM_FMT];
  logic [MINID_W-1:0]   mnr  [NUM_FMT];
  logic [NUM_FMT-1:0]   full, empty, pop;
  logic [CH_W-1:0]      win;
  logic                 any, load;

  logic                 out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [CH_W-1:0]      out_channel_q, out_channel_d;

  for (genvar k = 0; k < NUM_FMT; k++) begin : g_chan
    decode_chan_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clock_i),
      .rst_ni  (reset_i),
      .flush_i (flush_i),
      .push_i  (in_valid_i[k]),
      .pop_i   (pop[k]),
      .data_i  (in_payload_i[k*PAYLOAD_W +: PAYLOAD_W]),
      .head_o  (head[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .count_o (occupancy_o[k*CNT_W +: CNT_W])
    );
    assign maj[k] = head[k][MAJ_OFF +: MAJID_W];
    assign mnr[k] = head[k][MIN_OFF +: MINID_W];
    assign pop[k] = load && (win == CH_W'(k));
  end

  assign in_ready_o = ~full;

  // Strict "older" keeps the earlier (lower-index) candidate on a full tie.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_FMT; k++) begin
      if (!empty[k] && (!any || older(maj[k], mnr[k], maj[win], mnr[win]))) begin
        win = CH_W'(k);
        any = 1'b1;
      end
    end
  end

  assign load = (!out_valid_q || out_ready_i) && any;

  // Output stage: the winning head moves into the register on the same edge it is popped.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    out_channel_d = out_channel_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      out_valid_d = any;
      if (any) begin
        out_payload_d = head[win];
        out_channel_d = win;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_channel_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_payload_o = out_payload_q;
  assign out_channel_o = out_channel_q;

endmodule
